// File: rtl/vram_fill_writer_pkg.sv
// Shared constants, FSM encoding and command payload for the VRAM fill writer.
// The VRAM window constants are also used by the HDMI controller's sel decode.
package vram_fill_writer_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned IDX_W       = 16;
    localparam int unsigned PIX_W       = 8;
    localparam logic [31:0] VRAM_BASE   = 32'h0020_0000;
    localparam int unsigned VRAM_PIXELS = 57600;

    localparam logic [2:0] WE_BYTE = 3'b100;
    localparam logic [2:0] WE_NONE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic             fill;
        logic [IDX_W-1:0] addr;
        logic [IDX_W-1:0] len;
        logic [PIX_W-1:0] data;
    } cmd_t;

    // Non-empty run that ends inside the window; 17-bit sum so it cannot wrap.
    function automatic logic cmd_in_range(input logic [IDX_W-1:0] start,
                                          input logic [IDX_W-1:0] len,
                                          input int unsigned      depth);
        logic [IDX_W:0] end_idx;
        end_idx = (IDX_W+1)'(start) + (IDX_W+1)'(len);
        return (len != '0) && (32'(end_idx) <= depth);
    endfunction

endpackage

// File: rtl/vram_fill_writer.sv
// Command-driven single-pixel / run-fill writer for the HDMI controller VRAM port.
// Optional decrementing-gradient fills are enabled by VRAM_FILL_WRITER_GRADIENT_EN.
module vram_fill_writer
    import vram_fill_writer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = VRAM_BASE,
    parameter int unsigned VRAM_DEPTH = VRAM_PIXELS,
    parameter int unsigned XLEN       = XLEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_fill,
    input  logic             cmd_gradient,
    input  logic [IDX_W-1:0] cmd_addr,
    input  logic [IDX_W-1:0] cmd_len,
    input  logic [PIX_W-1:0] cmd_data,
    input  logic             hold,
    output logic             sel,
    output logic [XLEN-1:0]  addr,
    output logic [2:0]       we,
    output logic [XLEN-1:0]  qin,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [IDX_W-1:0] rem_q, rem_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             grad_q, grad_d;

    logic             sel_q, sel_d;
    logic [2:0]       we_q, we_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  qin_q, qin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;

    cmd_t             cmd;
    logic [IDX_W-1:0] eff_len;
    logic             cmd_ok;
    logic             grad_in;

    assign cmd     = '{fill: cmd_fill, addr: cmd_addr, len: cmd_len, data: cmd_data};
    assign eff_len = cmd.fill ? cmd.len : IDX_W'(1);
    assign cmd_ok  = cmd_in_range(cmd.addr, eff_len, VRAM_DEPTH);

`ifdef VRAM_FILL_WRITER_GRADIENT_EN
    assign grad_in = cmd_gradient;
`else
    logic unused_gradient;
    assign grad_in         = 1'b0;
    assign unused_gradient = cmd_gradient;
`endif

    // Outputs are computed one cycle ahead so the write for a cycle is on the
    // registered port during that cycle; hold therefore stalls the following cycle.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        pix_d   = pix_q;
        grad_d  = grad_q;
        sel_d   = 1'b0;
        we_d    = WE_NONE;
        addr_d  = addr_q;
        qin_d   = qin_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid && ready_q) begin
                    if (!cmd_ok) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                        sel_d   = 1'b1;
                        we_d    = WE_BYTE;
                        addr_d  = XLEN'(BASE_ADDR) + XLEN'(cmd.addr);
                        qin_d   = XLEN'(cmd.data);
                        cur_d   = cmd.addr + IDX_W'(1);
                        rem_d   = eff_len - IDX_W'(1);
                        pix_d   = cmd.data - PIX_W'(grad_in);
                        grad_d  = grad_in;
                    end
                end
            end
            ST_WRITE: begin
                busy_d = 1'b1;
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (!hold) begin
                    sel_d  = 1'b1;
                    we_d   = WE_BYTE;
                    addr_d = XLEN'(BASE_ADDR) + XLEN'(cur_q);
                    qin_d  = XLEN'(pix_q);
                    cur_d  = cur_q + IDX_W'(1);
                    rem_d  = rem_q - IDX_W'(1);
                    pix_d  = pix_q - PIX_W'(grad_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            pix_q   <= '0;
            grad_q  <= 1'b0;
            sel_q   <= 1'b0;
            we_q    <= WE_NONE;
            addr_q  <= XLEN'(BASE_ADDR);
            qin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            pix_q   <= pix_d;
            grad_q  <= grad_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            qin_q   <= qin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign sel       = sel_q;
    assign we        = we_q;
    assign addr      = addr_q;
    assign qin       = qin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vram_fill_writer.sv
// Self-checking bench for vram_fill_writer: directed scenarios plus randomized
// commands against a per-command write-list model (honours VRAM_FILL_WRITER_GRADIENT_EN).
module tb_vram_fill_writer;

    localparam int unsigned MAXC  = 48;
    localparam logic [31:0] BASE  = 32'h0020_0000;
    localparam int unsigned DEPTH = 57600;
`ifdef VRAM_FILL_WRITER_GRADIENT_EN
    localparam bit GRAD_EN = 1'b1;
`else
    localparam bit GRAD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_fill = 1'b0;
    logic        cmd_gradient = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic [7:0]  cmd_data = '0;
    logic        hold = 1'b0;
    logic        sel;
    logic [31:0] addr;
    logic [2:0]  we;
    logic [31:0] qin;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic        obs_sel  [MAXC];
    logic [2:0]  obs_we   [MAXC];
    logic [31:0] obs_addr [MAXC];
    logic [31:0] obs_qin  [MAXC];
    logic        obs_busy [MAXC];
    logic        obs_done [MAXC];
    logic        obs_err  [MAXC];
    logic        obs_rdy  [MAXC];

    int          exp_wcyc  [$];
    logic [31:0] exp_waddr [$];
    logic [7:0]  exp_wdata [$];
    bit          exp_err;
    int          exp_done;

    vram_fill_writer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_fill     (cmd_fill),
        .cmd_gradient (cmd_gradient),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_data     (cmd_data),
        .hold         (hold),
        .sel          (sel),
        .addr         (addr),
        .we           (we),
        .qin          (qin),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: list of (cycle, address, data) writes for one command, counting
    // cycles from acceptance; hold during cycle c pushes the next write past c+1.
    task automatic build_model(input bit fill, input bit grad, input int a, input int len,
                               input logic [7:0] d, input bit [MAXC-1:0] hm);
        int n;
        int c;
        exp_wcyc.delete();
        exp_waddr.delete();
        exp_wdata.delete();
        n        = fill ? len : 1;
        exp_err  = (n == 0) || (a + n > int'(DEPTH));
        exp_done = -1;
        if (!exp_err) begin
            c = 1;
            for (int i = 0; i < n; i++) begin
                exp_wcyc.push_back(c);
                exp_waddr.push_back(BASE + 32'(a + i));
                exp_wdata.push_back(d - ((GRAD_EN && grad) ? 8'(i) : 8'd0));
                c++;
                while (c < int'(MAXC) && hm[c-1]) c++;
            end
            exp_done = exp_wcyc[n-1] + 1;
        end
    endtask

    // Offer one command at the first ready cycle and record MAXC-1 cycles after acceptance.
    task automatic exec(input bit fill, input bit grad, input int a, input int len,
                        input logic [7:0] d, input bit [MAXC-1:0] hm);
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait got=%b exp=1", cmd_ready);
        end
        cmd_fill     = fill;
        cmd_gradient = grad;
        cmd_addr     = 16'(a);
        cmd_len      = 16'(len);
        cmd_data     = d;
        cmd_valid    = 1'b1;
        hold         = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k < int'(MAXC); k++) begin
            obs_sel[k]  = sel;
            obs_we[k]   = we;
            obs_addr[k] = addr;
            obs_qin[k]  = qin;
            obs_busy[k] = busy;
            obs_done[k] = done;
            obs_err[k]  = err;
            obs_rdy[k]  = cmd_ready;
            hold        = hm[k];
            @(negedge clk);
        end
        hold = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({sel, we, busy, done, err, cmd_ready} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0", {sel, we, busy, done, err, cmd_ready});
        end
        checks++;
        if (addr !== BASE) begin
            errors++;
            $display("FAIL reset_addr got=%h exp=%h", addr, BASE);
        end
        checks++;
        if (qin !== 32'h0) begin
            errors++;
            $display("FAIL reset_qin got=%h exp=0", qin);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_single();
        int nsel;
        exec(1'b0, 1'b0, 5, 7, 8'hA5, '0);
        checks++;
        if ({obs_sel[1], obs_we[1]} !== 4'b1100) begin
            errors++;
            $display("FAIL single_sel_we got=%b exp=1100", {obs_sel[1], obs_we[1]});
        end
        checks++;
        if (obs_addr[1] !== 32'h0020_0005) begin
            errors++;
            $display("FAIL single_addr got=%h exp=00200005", obs_addr[1]);
        end
        checks++;
        if (obs_qin[1] !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL single_qin got=%h exp=000000a5", obs_qin[1]);
        end
        checks++;
        if ({obs_done[2], obs_sel[2], obs_rdy[2], obs_busy[2]} !== 4'b1000) begin
            errors++;
            $display("FAIL single_done got=%b exp=1000", {obs_done[2], obs_sel[2], obs_rdy[2], obs_busy[2]});
        end
        checks++;
        if ({obs_rdy[3], obs_done[3]} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready_back got=%b exp=10", {obs_rdy[3], obs_done[3]});
        end
        nsel = 0;
        for (int k = 1; k < int'(MAXC); k++) nsel += int'(obs_sel[k]);
        checks++;
        if (nsel != 1) begin
            errors++;
            $display("FAIL single_len_ignored got=%0d exp=1", nsel);
        end
    endtask

    task automatic test_fill();
        int nbusy;
        exec(1'b1, 1'b0, 100, 4, 8'h10, '0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_sel[1+i] !== 1'b1 || obs_addr[1+i] !== 32'h0020_0064 + 32'(i)
                || obs_qin[1+i] !== 32'h10) begin
                errors++;
                $display("FAIL fill_write%0d got sel=%b addr=%h qin=%h exp sel=1 addr=%h qin=10",
                         i, obs_sel[1+i], obs_addr[1+i], obs_qin[1+i], 32'h0020_0064 + 32'(i));
            end
        end
        nbusy = 0;
        for (int k = 1; k < int'(MAXC); k++) nbusy += int'(obs_busy[k]);
        checks++;
        if (nbusy != 4) begin
            errors++;
            $display("FAIL fill_busy_cycles got=%0d exp=4", nbusy);
        end
        checks++;
        if ({obs_done[5], obs_sel[5]} !== 2'b10) begin
            errors++;
            $display("FAIL fill_done got=%b exp=10", {obs_done[5], obs_sel[5]});
        end
    endtask

    task automatic test_boundary();
        int nsel;
        int nrdy;
        exec(1'b1, 1'b0, 57599, 1, 8'h5A, '0);
        checks++;
        if (obs_sel[1] !== 1'b1 || obs_addr[1] !== 32'h0020_E0FF) begin
            errors++;
            $display("FAIL bound_last got sel=%b addr=%h exp sel=1 addr=0020e0ff", obs_sel[1], obs_addr[1]);
        end
        for (int v = 0; v < 2; v++) begin
            exec(1'b1, 1'b0, (v == 0) ? 57599 : 10, (v == 0) ? 2 : 0, 8'h11, '0);
            nsel = 0;
            nrdy = 0;
            for (int k = 1; k < int'(MAXC); k++) begin
                nsel += int'(obs_sel[k]);
                nrdy += int'(obs_rdy[k]);
            end
            checks++;
            if ({obs_err[1], obs_err[2]} !== 2'b10) begin
                errors++;
                $display("FAIL bound_err%0d got=%b exp=10", v, {obs_err[1], obs_err[2]});
            end
            checks++;
            if (nsel != 0 || nrdy != int'(MAXC) - 1) begin
                errors++;
                $display("FAIL bound_reject%0d got sel=%0d ready=%0d exp sel=0 ready=%0d",
                         v, nsel, nrdy, MAXC - 1);
            end
        end
    endtask

    task automatic test_hold();
        bit [MAXC-1:0] hm;
        bit            exp_s [7];
        int            nbusy;
        hm    = '0;
        hm[1] = 1'b1;
        hm[2] = 1'b1;
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exec(1'b1, 1'b0, 20, 3, 8'h77, hm);
        for (int k = 1; k < 7; k++) begin
            checks++;
            if (obs_sel[k] !== exp_s[k]) begin
                errors++;
                $display("FAIL hold_sel_c%0d got=%b exp=%b", k, obs_sel[k], exp_s[k]);
            end
        end
        checks++;
        if (obs_addr[2] !== BASE + 32'd20 || obs_we[2] !== 3'b000) begin
            errors++;
            $display("FAIL hold_stall got addr=%h we=%b exp addr=%h we=000", obs_addr[2], obs_we[2], BASE + 32'd20);
        end
        checks++;
        if (obs_addr[4] !== BASE + 32'd21 || obs_addr[5] !== BASE + 32'd22) begin
            errors++;
            $display("FAIL hold_resume got=%h,%h exp=%h,%h", obs_addr[4], obs_addr[5], BASE + 32'd21, BASE + 32'd22);
        end
        nbusy = 0;
        for (int k = 1; k < int'(MAXC); k++) nbusy += int'(obs_busy[k]);
        checks++;
        if (nbusy != 5 || obs_done[6] !== 1'b1) begin
            errors++;
            $display("FAIL hold_busy got busy=%0d done6=%b exp busy=5 done6=1", nbusy, obs_done[6]);
        end
    endtask

    task automatic test_gradient();
        logic [7:0] exp_q [3];
        exp_q = GRAD_EN ? '{8'h01, 8'h00, 8'hFF} : '{8'h01, 8'h01, 8'h01};
        exec(1'b1, 1'b1, 0, 3, 8'h01, '0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_qin[1+i] !== {24'h0, exp_q[i]}) begin
                errors++;
                $display("FAIL grad_qin%0d got=%h exp=%h", i, obs_qin[1+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        cmd_fill  = 1'b1;
        cmd_addr  = 16'd200;
        cmd_len   = 16'd10;
        cmd_data  = 8'h33;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sel !== 1'b1 || addr !== BASE + 32'(200 + k)) begin
                errors++;
                $display("FAIL rmid_write%0d got sel=%b addr=%h exp sel=1 addr=%h", k, sel, addr, BASE + 32'(200 + k));
            end
            if (k < 3) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sel, we, busy, done, cmd_ready} !== 7'b0 || addr !== BASE || qin !== 32'h0) begin
            errors++;
            $display("FAIL rmid_async got ctrl=%b addr=%h qin=%h exp ctrl=0 addr=%h qin=0",
                     {sel, we, busy, done, cmd_ready}, addr, qin, BASE);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || sel !== 1'b0) begin
                errors++;
                $display("FAIL rmid_quiet%0d got done=%b sel=%b exp 0 0", k, done, sel);
            end
        end
        exec(1'b1, 1'b0, 300, 2, 8'h44, '0);
        checks++;
        if ({obs_sel[1], obs_sel[2], obs_done[3]} !== 3'b111 || obs_addr[1] !== BASE + 32'd300
            || obs_qin[2] !== 32'h44) begin
            errors++;
            $display("FAIL rmid_restart got sel/done=%b addr=%h qin=%h exp 111 %h 44",
                     {obs_sel[1], obs_sel[2], obs_done[3]}, obs_addr[1], BASE + 32'd300, obs_qin[2]);
        end
    endtask

    task automatic test_random();
        bit            fill;
        bit            grad;
        int            a;
        int            len;
        logic [7:0]    d;
        bit [MAXC-1:0] hm;
        int            j;
        bit            es;
        for (int n = 0; n < 40; n++) begin
            fill = ($urandom_range(0, 3) != 0);
            grad = 1'($urandom_range(0, 1));
            len  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            a    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(DEPTH - 12, DEPTH - 1))
                                                : int'($urandom_range(0, DEPTH - 1));
            d    = 8'($urandom);
            hm   = '0;
            for (int k = 1; k < 24; k++) hm[k] = ($urandom_range(0, 3) == 0);
            build_model(fill, grad, a, len, d, hm);
            exec(fill, grad, a, len, d, hm);
            j = 0;
            for (int k = 1; k < int'(MAXC); k++) begin
                es = (j < exp_wcyc.size()) && (exp_wcyc[j] == k);
                checks++;
                if (obs_sel[k] !== es || obs_we[k] !== (es ? 3'b100 : 3'b000)) begin
                    errors++;
                    $display("FAIL rnd%0d_sel_c%0d got sel=%b we=%b exp sel=%b", n, k, obs_sel[k], obs_we[k], es);
                end
                if (es) begin
                    checks++;
                    if (obs_addr[k] !== exp_waddr[j] || obs_qin[k] !== {24'h0, exp_wdata[j]}) begin
                        errors++;
                        $display("FAIL rnd%0d_data_c%0d got addr=%h qin=%h exp addr=%h qin=%h",
                                 n, k, obs_addr[k], obs_qin[k], exp_waddr[j], exp_wdata[j]);
                    end
                    j++;
                end else if (j > 0 && k < exp_done) begin
                    checks++;
                    if (obs_addr[k] !== exp_waddr[j-1]) begin
                        errors++;
                        $display("FAIL rnd%0d_stall_c%0d got addr=%h exp=%h", n, k, obs_addr[k], exp_waddr[j-1]);
                    end
                end
                checks++;
                if (obs_busy[k] !== (!exp_err && k < exp_done) || obs_done[k] !== (k == exp_done)
                    || obs_err[k] !== (exp_err && k == 1)
                    || obs_rdy[k] !== (exp_err || k > exp_done)) begin
                    errors++;
                    $display("FAIL rnd%0d_ctrl_c%0d got busy/done/err/rdy=%b%b%b%b exp=%b%b%b%b",
                             n, k, obs_busy[k], obs_done[k], obs_err[k], obs_rdy[k],
                             (!exp_err && k < exp_done), (k == exp_done), (exp_err && k == 1),
                             (exp_err || k > exp_done));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_boundary();
        test_hold();
        test_gradient();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
